category_argmax_seq: RTL

//   Sequential successor to the combinational per-category popcount + arg-max stage after the logic-gate net.

---
 rtl/category_argmax_seq_if.sv | 30 +++
 rtl/category_argmax_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/category_argmax_seq_if.sv
// Handshake bundle for category_argmax_seq: vector in, winning index/score out.
// The out_margin signal exists only when CATEGORY_MARGIN_EN is defined.
interface category_argmax_seq_if #(
  parameter int CATEGORIES        = 10,
  parameter int BITS_PER_CATEGORY = 512,
  parameter int SUM_W             = $clog2(BITS_PER_CATEGORY + 1),
  parameter int IDX_W             = $clog2(CATEGORIES)
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [CATEGORIES*BITS_PER_CATEGORY-1:0] in_cats;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [IDX_W-1:0]                      out_index;
  logic [SUM_W-1:0]                      out_value;
  logic                                  busy;
`ifdef CATEGORY_MARGIN_EN
  logic [SUM_W-1:0]                      out_margin;

  modport master (output in_valid, in_cats, out_ready,
                  input  in_ready, out_valid, out_index, out_value, busy, out_margin);
  modport slave  (input  in_valid, in_cats, out_ready,
                  output in_ready, out_valid, out_index, out_value, busy, out_margin);
`else
  modport master (output in_valid, in_cats, out_ready,
                  input  in_ready, out_valid, out_index, out_value, busy);
  modport slave  (input  in_valid, in_cats, out_ready,
                  output in_ready, out_valid, out_index, out_value, busy);
`endif
endinterface

// File: rtl/category_argmax_seq.sv
// Sequential per-category popcount and arg-max: CHUNK bits counted per cycle, one comparator.
// Optional CATEGORY_MARGIN_EN adds second-best tracking and the out_margin output.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a category vector
//   COUNT | popcounting chunks, folding category sums into best; one extra publish cycle at the end
//   DONE  | result held on out_* until out_ready
module category_argmax_seq #(
  parameter int CATEGORIES        = 10,
  parameter int BITS_PER_CATEGORY = 512,
  parameter int CHUNK             = 64
) (
  input logic                   clk,
  input logic                   rst,
  category_argmax_seq_if.slave  bus
);
  localparam int SUM_W   = $clog2(BITS_PER_CATEGORY + 1);
  localparam int IDX_W   = $clog2(CATEGORIES);
  localparam int NCH     = BITS_PER_CATEGORY / CHUNK;
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TOTAL_W = CATEGORIES * BITS_PER_CATEGORY;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NCH - 1);
  localparam logic [IDX_W-1:0] LAST_CAT = IDX_W'(CATEGORIES - 1);

  if ((BITS_PER_CATEGORY % CHUNK) != 0) begin : g_chunk_check
    $error("CHUNK must divide BITS_PER_CATEGORY");
  end

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t             state;
  logic [TOTAL_W-1:0] vec;
  logic [IDX_W-1:0]   cat;
  logic [CH_W-1:0]    chunk;
  logic [SUM_W-1:0]   acc;
  logic [SUM_W-1:0]   best_val;
  logic [IDX_W-1:0]   best_idx;
  logic               fin;
  logic               in_ready_r, out_valid_r, busy_r;
  logic [IDX_W-1:0]   out_index_r;
  logic [SUM_W-1:0]   out_value_r;
`ifdef CATEGORY_MARGIN_EN
  logic [SUM_W-1:0]   second_val;
  logic [SUM_W-1:0]   out_margin_r;
`endif

  logic [CHUNK-1:0]   chunk_bits;
  logic [SUM_W-1:0]   chunk_cnt;
  logic [SUM_W-1:0]   total;

  always_comb begin
    chunk_bits = '0;
    chunk_bits = vec[int'(cat)*BITS_PER_CATEGORY + int'(chunk)*CHUNK +: CHUNK];
    chunk_cnt  = '0;
    for (int i = 0; i < CHUNK; i++) chunk_cnt = chunk_cnt + SUM_W'(chunk_bits[i]);
    total      = acc + chunk_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vec         <= '0;
      cat         <= '0;
      chunk       <= '0;
      acc         <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      fin         <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_index_r <= '0;
      out_value_r <= '0;
`ifdef CATEGORY_MARGIN_EN
      second_val   <= '0;
      out_margin_r <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            vec        <= bus.in_cats;
            cat        <= '0;
            chunk      <= '0;
            acc        <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            fin        <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= COUNT;
`ifdef CATEGORY_MARGIN_EN
            second_val <= '0;
`endif
          end
        end
        COUNT: begin
          if (fin) begin
            out_index_r <= best_idx;
            out_value_r <= best_val;
            out_valid_r <= 1'b1;
            fin         <= 1'b0;
            state       <= DONE;
`ifdef CATEGORY_MARGIN_EN
            out_margin_r <= best_val - second_val;
`endif
          end else if (chunk == LAST_CH) begin
            // Strict compare keeps the lower index on ties.
            if (cat == '0 || total > best_val) begin
              best_val <= total;
              best_idx <= cat;
`ifdef CATEGORY_MARGIN_EN
              second_val <= (cat == '0) ? '0 : best_val;
`endif
            end
`ifdef CATEGORY_MARGIN_EN
            else if (total > second_val) begin
              second_val <= total;
            end
`endif
            acc   <= '0;
            chunk <= '0;
            if (cat == LAST_CAT) fin <= 1'b1;
            else                 cat <= cat + 1'b1;
          end else begin
            acc   <= total;
            chunk <= chunk + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out_index = out_index_r;
  assign bus.out_value = out_value_r;
`ifdef CATEGORY_MARGIN_EN
  assign bus.out_margin = out_margin_r;
`endif
endmodule
